// File: rtl/blockmem_word_loader_if.sv
// Byte-stream input and word-memory write port of the block loader.
// The master modport is the loader's view; slave is the environment's view.
interface blockmem_word_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_rst;
    logic        mem_cs;
    logic        mem_wr;
    logic [31:0] mem_write_data;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready, mem_rst, mem_cs, mem_wr, mem_write_data
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready, mem_rst, mem_cs, mem_wr, mem_write_data
    );
endinterface

// File: rtl/blockmem_word_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes up to NUM_WORDS
// of them into a pointer-addressed memory per start request.
module blockmem_word_loader #(
    parameter int NUM_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    blockmem_word_loader_if.master bus,
    output logic [8:0]            word_count,
    output logic                  busy,
    output logic                  block_done,
    output logic                  msg_end
);

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, WRITE, DONE} state_t;

    localparam logic [8:0] LAST_COUNT = 9'(NUM_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] pack_q, pack_d;
    logic [8:0]  word_count_q, word_count_d;
    logic        msg_end_q, msg_end_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            byte_idx_q   <= 2'd0;
            pack_q       <= 32'd0;
            word_count_q <= 9'd0;
            msg_end_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            pack_q       <= pack_d;
            word_count_q <= word_count_d;
            msg_end_q    <= msg_end_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        pack_d       = pack_q;
        word_count_d = word_count_q;
        msg_end_d    = msg_end_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    msg_end_d = 1'b0;
                end
            end
            CLEAR: begin
                word_count_d = 9'd0;
                byte_idx_d   = 2'd0;
                pack_d       = 32'd0;
                msg_end_d    = 1'b0;
                state_d      = FILL;
            end
            FILL: begin
                // in_ready is high for the whole of FILL, so in_valid alone accepts
                if (bus.in_valid) begin
                    case (byte_idx_q)
                        2'd0:    pack_d[31:24] = bus.in_data;
                        2'd1:    pack_d[23:16] = bus.in_data;
                        2'd2:    pack_d[15:8]  = bus.in_data;
                        default: pack_d[7:0]   = bus.in_data;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (bus.in_last) begin
                        msg_end_d = 1'b1;
                    end
                    if (byte_idx_q == 2'd3 || bus.in_last) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + 9'd1;
                if (word_count_d == LAST_COUNT || msg_end_q) begin
                    state_d = DONE;
                end else begin
                    state_d    = FILL;
                    byte_idx_d = 2'd0;
                    pack_d     = 32'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready       = (state_q == FILL);
    assign bus.mem_rst        = (state_q == CLEAR);
    assign bus.mem_cs         = (state_q == WRITE);
    assign bus.mem_wr         = (state_q == WRITE);
    assign bus.mem_write_data = pack_q;
    assign word_count         = word_count_q;
    assign busy               = (state_q != IDLE);
    assign block_done         = (state_q == DONE);
    assign msg_end            = msg_end_q;

endmodule

// File: tb/tb_blockmem_word_loader.sv
// Directed and randomized checks of blockmem_word_loader against a
// byte-list-to-word reference model.
module tb_blockmem_word_loader;

    localparam int NUM_WORDS = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] word_count;
    logic       busy;
    logic       block_done;
    logic       msg_end;

    blockmem_word_loader_if bus ();

    blockmem_word_loader #(.NUM_WORDS(NUM_WORDS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus),
        .word_count (word_count),
        .busy       (busy),
        .block_done (block_done),
        .msg_end    (msg_end)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [31:0] obs_q[$];
    int          wr_cyc_q[$];
    int          rst_count = 0;
    int          done_count = 0;
    int          viol_count = 0;
    int          rdy_count = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: memory writes, pulses and handshake-rule violations
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mem_wr) begin
                obs_q.push_back(bus.mem_write_data);
                wr_cyc_q.push_back(cyc);
            end
            if (bus.mem_rst) rst_count++;
            if (block_done) done_count++;
            if (bus.in_ready) rdy_count++;
            if ((bus.mem_cs !== bus.mem_wr) ||
                (bus.mem_rst && (bus.mem_cs || bus.mem_wr)) ||
                (bus.mem_wr && bus.in_ready))
                viol_count++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: consecutive groups of four bytes, first byte most significant,
    // short final group zero-padded, at most NUM_WORDS words per block.
    task automatic build_expected();
        int nwords;
        logic [31:0] word;
        logic [31:0] tmp;
        exp_q.delete();
        nwords = (tx_q.size() + 3) / 4;
        if (nwords > NUM_WORDS) nwords = NUM_WORDS;
        for (int w = 0; w < nwords; w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < tx_q.size()) begin
                    tmp = 32'(tx_q[4 * w + b]);
                    word = word | (tmp << (24 - 8 * b));
                end
            end
            exp_q.push_back(word);
        end
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output({tag, "_mem_rst_after_start"}, 32'(bus.mem_rst), 32'd1);
    endtask

    task automatic apply_stimulus(input int n, input bit with_last, input int gap_pct);
        int i;
        int budget;
        logic rdy;
        i = 0;
        budget = 0;
        while (i < n && budget < 3000) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                bus.in_data  = 8'h5A;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = tx_q[i];
                bus.in_last  = with_last && (i == n - 1);
            end
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (bus.in_valid && rdy) i++;
            budget++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        check_output("bytes_accepted", 32'(i), 32'(n));
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_count == base && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_output("done_within_budget", 32'(n < 500), 32'd1);
    endtask

    task automatic run_block(input string tag, input bit with_last, input int gap_pct,
                             input bit poke_start);
        int wr_base;
        int rst_base;
        int done_base;
        int viol_base;
        logic [31:0] o;
        wr_base   = obs_q.size();
        rst_base  = rst_count;
        done_base = done_count;
        viol_base = viol_count;
        build_expected();
        pulse_start(tag);
        if (poke_start) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        apply_stimulus(tx_q.size(), with_last, gap_pct);
        wait_done(done_base);
        repeat (2) @(posedge clk);
        #1;
        check_output({tag, "_write_count"}, 32'(obs_q.size() - wr_base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            o = (wr_base + k < obs_q.size()) ? obs_q[wr_base + k] : 32'hxxxx_xxxx;
            check_output($sformatf("%s_word%0d", tag, k), o, exp_q[k]);
        end
        check_output({tag, "_word_count"}, 32'(word_count), 32'(exp_q.size()));
        check_output({tag, "_msg_end"}, 32'(msg_end), 32'(with_last));
        check_output({tag, "_block_done_pulses"}, 32'(done_count - done_base), 32'd1);
        check_output({tag, "_mem_rst_pulses"}, 32'(rst_count - rst_base), 32'd1);
        check_output({tag, "_rule_violations"}, 32'(viol_count - viol_base), 32'd0);
        check_output({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int wr_base;
        int rdy_base;
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;

        #1;
        check_output("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("reset_mem_rst", 32'(bus.mem_rst), 32'd0);
        check_output("reset_mem_cs", 32'(bus.mem_cs), 32'd0);
        check_output("reset_mem_wr", 32'(bus.mem_wr), 32'd0);
        check_output("reset_mem_data", bus.mem_write_data, 32'd0);
        check_output("reset_word_count", 32'(word_count), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_block_done", 32'(block_done), 32'd0);
        check_output("reset_msg_end", 32'(msg_end), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full block, in_valid held, ascending bytes
        $display("[TB] full block 0x00..0x3F");
        tx_q.delete();
        for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
        wr_base = obs_q.size();
        run_block("full", 1'b0, 0, 1'b0);
        check_output("full_first_word", (obs_q.size() > wr_base) ? obs_q[wr_base] : 32'hx,
                     32'h0001_0203);
        check_output("full_last_word", (obs_q.size() >= wr_base + 16) ? obs_q[wr_base + 15] : 32'hx,
                     32'h3C3D_3E3F);
        check_output("full_throughput_cycles",
                     (wr_cyc_q.size() >= wr_base + 16) ?
                         32'(wr_cyc_q[wr_base + 15] - wr_cyc_q[wr_base]) : 32'hx,
                     32'd75);

        // Bytes offered after the block filled must wait for the next start
        wr_base  = obs_q.size();
        rdy_base = rdy_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        repeat (10) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("overflow_no_writes", 32'(obs_q.size() - wr_base), 32'd0);
        check_output("overflow_no_ready", 32'(rdy_count - rdy_base), 32'd0);

        $display("[TB] short message AA BB CC");
        tx_q.delete();
        tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
        wr_base = obs_q.size();
        run_block("short3", 1'b1, 0, 1'b0);
        check_output("short3_word", (obs_q.size() > wr_base) ? obs_q[wr_base] : 32'hx,
                     32'hAABB_CC00);

        $display("[TB] 8-byte message, last on byte index 3");
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(8'(8'h11 + i));
        run_block("exact8", 1'b1, 0, 1'b1);

        $display("[TB] full block with random in_valid gaps");
        tx_q.delete();
        for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
        run_block("gaps", 1'b0, 40, 1'b0);

        $display("[TB] random messages");
        for (int m = 0; m < 5; m++) begin
            tx_q.delete();
            n = $urandom_range(1, 60);
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(255)));
            run_block($sformatf("rand%0d", m), 1'b1, 25, 1'b0);
        end

        $display("[TB] reset in the middle of a block");
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(8'(8'h40 + i));
        pulse_start("midreset");
        apply_stimulus(6, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        check_output("midreset_busy", 32'(busy), 32'd0);
        check_output("midreset_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("midreset_mem_data", bus.mem_write_data, 32'd0);
        check_output("midreset_word_count", 32'(word_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_base  = obs_q.size();
        rdy_base = rdy_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        repeat (10) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("midreset_no_writes", 32'(obs_q.size() - wr_base), 32'd0);
        check_output("midreset_no_ready", 32'(rdy_count - rdy_base), 32'd0);
        tx_q.delete();
        tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
        run_block("postreset", 1'b1, 0, 1'b0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/blockmem_word_loader.md
BLOCKMEM_WORD_LOADER -- requirements
Module: blockmem_word_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16, meaning words per block; legal range 1..256.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to load one block.
REQ-005 SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port in_data  input  8  byte-stream data.
REQ-007 SHALL have port in_last  input  1  marks final byte of message; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  byte-stream ready.
REQ-009 SHALL have port mem_rst  output  1  downstream pointer clear.
REQ-010 SHALL have port mem_cs  output  1  downstream pointer increment.
REQ-011 SHALL have port mem_wr  output  1  downstream write at current pointer.
REQ-012 SHALL have port mem_write_data  output  32  downstream write word.
REQ-013 SHALL have port word_count  output  9  words written in current/last block.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port block_done  output  1  single-cycle completion pulse.
REQ-016 SHALL have port msg_end  output  1  sticky: last block ended by in_last; cleared on accepted start.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, FILL, WRITE, DONE.
REQ-018 IDLE: start=1 -> CLEAR next cycle; start ignored in every other state.
REQ-019 CLEAR: mem_rst=1 for exactly one cycle; word_count, byte index, msg_end cleared; -> FILL.
REQ-020 FILL: in_ready=1; byte accepted iff in_valid & in_ready on a rising edge.
REQ-021 Packing big-endian: byte index 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0.
REQ-022 FILL -> WRITE after acceptance of byte index 3 or of any byte with in_last=1.
REQ-023 On in_last at byte index <3, unfilled lower bytes SHALL be 0x00; msg_end set.
REQ-024 WRITE: mem_wr=1 and mem_cs=1 for exactly one cycle, mem_write_data stable = packed word; in_ready=0; word_count increments by 1 at end of cycle.
REQ-025 WRITE -> DONE if (word_count+1 == NUM_WORDS) or msg_end; else -> FILL with byte index 0 and packing register cleared.
REQ-026 DONE: block_done=1 one cycle; -> IDLE; word_count holds until next CLEAR.
REQ-027 mem_rst SHALL never be asserted in the same cycle as mem_cs or mem_wr.
REQ-028 mem_cs and mem_wr SHALL always be asserted together; exactly word_count write pulses per block.
REQ-029 in_ready SHALL be 0 in IDLE, CLEAR, WRITE, DONE; no byte lost or duplicated across in_valid gaps.
REQ-030 in_last on byte index 3: exactly one write, no extra padding word.
REQ-031 NUM_WORDS reached without in_last: block ends, msg_end=0; subsequent bytes wait for next start.
REQ-032 NUM_WORDS=256: word_count reaches 256 without wrap (9-bit).
REQ-033 Max throughput: one word per 5 cycles (4 FILL + 1 WRITE) with in_valid held high.

Reset
REQ-034 reset_n=0 SHALL immediately force state IDLE, in_ready=0, mem_rst=0, mem_cs=0, mem_wr=0, mem_write_data=0, word_count=0, busy=0, block_done=0, msg_end=0.
REQ-035 Reset mid-block SHALL abandon partial word with no further memory writes; first post-reset block starts with mem_rst pulse.

Verification
REQ-036 NUM_WORDS=16, start, 64 bytes 0x00..0x3F, in_valid held -> 16 writes, first 0x00010203, last 0x3C3D3E3F, word_count=16, block_done once, msg_end=0.
REQ-037 start, bytes 0xAA,0xBB,0xCC with in_last on 0xCC -> one write 0xAABBCC00, word_count=1, msg_end=1, block_done.
REQ-038 start, 8 bytes 0x11..0x18, in_last on 0x18 -> writes 0x11121314, 0x15161718 only, word_count=2.
REQ-039 Random in_valid gaps over 64 bytes -> write data identical to REQ-036; in_ready low during every WRITE.
REQ-040 reset_n low after 6 bytes of a block -> no mem_wr until next start; next block begins with mem_rst pulse, word_count=0.
REQ-041 start asserted while busy -> ignored; mem_rst pulses exactly once per accepted start.
